// File: rtl/alu_flags_unit.sv
// alu_flags_unit: latches ALU result/flags, evaluates branch conditions and sequences chained carry/zero; define FLAGS_BYPASS_EN to forward flags_in to cond_true/carry_to_alu
module alu_flags_unit #(
  parameter int MAX_LEN_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           result_in,
  input  logic [3:0]           flags_in,
  input  logic                 we_result,
  input  logic                 we_flags,
  input  logic                 carry_init,
  input  logic                 chain_start,
  input  logic [MAX_LEN_W-1:0] chain_len,
  input  logic [3:0]           cond,
  output logic [7:0]           result_q,
  output logic [3:0]           flags_q,
  output logic                 carry_to_alu,
  output logic                 cond_true,
  output logic                 chain_busy,
  output logic                 chain_done
);
  typedef enum logic {IDLE, CHAIN} state_t;
  state_t state, state_n;
  logic [MAX_LEN_W-1:0] cnt, cnt_n;
  logic first, first_n, count_byte, last_byte, z_in;
  logic [3:0] flags_new, flags_n, cf;
  logic [15:0] ct;
  always_comb begin
    count_byte = state == CHAIN && we_flags && !chain_start;
    last_byte = count_byte && cnt == '0;
    z_in = first ? flags_in[0] : flags_q[0] & flags_in[0];
    flags_new = count_byte ? {flags_in[3:1], z_in} : flags_in;
    flags_n = we_flags ? flags_new : flags_q;
    state_n = chain_start ? CHAIN : last_byte ? IDLE : state;
    cnt_n = chain_start ? chain_len : (count_byte && cnt != '0) ? cnt - 1'b1 : cnt;
    first_n = chain_start ? 1'b1 : count_byte ? 1'b0 : first;
`ifdef FLAGS_BYPASS_EN
    cf = we_flags ? flags_new : flags_q;
    carry_to_alu = (state == IDLE || first) ? carry_init : we_flags ? flags_in[1] : flags_q[1];
`else
    cf = flags_q;
    carry_to_alu = (state == IDLE || first) ? carry_init : flags_q[1];
`endif
    ct = {3'b000, 1'b1, ~cf[1] | cf[0], cf[1] & ~cf[0], ~(cf[2] ^ cf[3]), cf[2] ^ cf[3],
          ~cf[3], cf[3], ~cf[2], cf[2], ~cf[1], cf[1], ~cf[0], cf[0]};
    cond_true = ct[cond];
    chain_busy = state == CHAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q <= '0;
      state <= IDLE;
      cnt <= '0;
      first <= 1'b0;
      chain_done <= 1'b0;
    end else begin
      if (we_result) result_q <= result_in;
      flags_q <= flags_n;
      state <= state_n;
      cnt <= cnt_n;
      first <= first_n;
      chain_done <= last_byte;
    end
  end
endmodule

// File: tb/tb_alu_flags_unit.sv
// tb_alu_flags_unit: directed vectors with hand-computed expectations for alu_flags_unit
module tb_alu_flags_unit;
  logic clk = 1'b0;
  logic rst, we_result, we_flags, carry_init, chain_start;
  logic [7:0] result_in, result_q;
  logic [3:0] flags_in, cond, flags_q;
  logic [2:0] chain_len;
  logic carry_to_alu, cond_true, chain_busy, chain_done;
  int n_cmp = 0;
  int n_bad = 0;
  alu_flags_unit #(.MAX_LEN_W(3)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .flags_in(flags_in),
    .we_result(we_result), .we_flags(we_flags), .carry_init(carry_init),
    .chain_start(chain_start), .chain_len(chain_len), .cond(cond),
    .result_q(result_q), .flags_q(flags_q), .carry_to_alu(carry_to_alu),
    .cond_true(cond_true), .chain_busy(chain_busy), .chain_done(chain_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cond(input logic [3:0] c, input logic exp);
    cond = c;
    #1;
    check($sformatf("cond%0d", c), {7'd0, cond_true}, {7'd0, exp});
  endtask
  task automatic load_byte(input logic [7:0] r, input logic [3:0] f);
    result_in = r;
    flags_in = f;
    we_flags = 1'b1;
    we_result = 1'b1;
    tick();
    we_flags = 1'b0;
    we_result = 1'b0;
    #1;
  endtask
  task automatic start(input logic [2:0] len, input logic ci);
    chain_len = len;
    carry_init = ci;
    chain_start = 1'b1;
    tick();
    chain_start = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1; we_flags = 1'b1; we_result = 1'b1; flags_in = 4'hF; result_in = 8'hAA;
    carry_init = 1'b0; chain_start = 1'b0; chain_len = '0; cond = 4'd12;
    tick();
    tick();
    check("rst_flags", {4'd0, flags_q}, 8'h00);
    check("rst_result", result_q, 8'h00);
    check("rst_busy", {7'd0, chain_busy}, 8'd0);
    check("rst_done", {7'd0, chain_done}, 8'd0);
    chk_cond(4'd12, 1'b1);
    chk_cond(4'd0, 1'b0);
    rst = 1'b0; we_flags = 1'b0; we_result = 1'b0;
    load_byte(8'h5C, 4'b1010);
    check("single_flags", {4'd0, flags_q}, 8'h0A);
    check("single_result", result_q, 8'h5C);
    chk_cond(4'd2, 1'b1);
    chk_cond(4'd6, 1'b1);
    chk_cond(4'd8, 1'b1);
    chk_cond(4'd10, 1'b1);
    chk_cond(4'd1, 1'b1);
    chk_cond(4'd0, 1'b0);
    chk_cond(4'd9, 1'b0);
    chk_cond(4'd11, 1'b0);
    chk_cond(4'd4, 1'b0);
    chk_cond(4'd5, 1'b1);
    chk_cond(4'd14, 1'b0);
    start(3'd1, 1'b0);
    check("add_busy", {7'd0, chain_busy}, 8'd1);
    check("add_c0", {7'd0, carry_to_alu}, 8'd0);
    load_byte(8'h00, 4'b0011);
    check("add_b0_res", result_q, 8'h00);
    check("add_c1", {7'd0, carry_to_alu}, 8'd1);
    check("add_b0_done", {7'd0, chain_done}, 8'd0);
    load_byte(8'h02, 4'b0000);
    check("add_res", result_q, 8'h02);
    check("add_done", {7'd0, chain_done}, 8'd1);
    check("add_flags", {4'd0, flags_q}, 8'h00);
    check("add_idle", {7'd0, chain_busy}, 8'd0);
    tick();
    check("add_done_pulse", {7'd0, chain_done}, 8'd0);
    start(3'd2, 1'b0);
    load_byte(8'h00, 4'b0001);
    check("z3_b0", {4'd0, flags_q}, 8'h01);
    load_byte(8'h00, 4'b0001);
    load_byte(8'h00, 4'b0001);
    check("z3_done", {7'd0, chain_done}, 8'd1);
    check("z3_z", {7'd0, flags_q[0]}, 8'd1);
    start(3'd2, 1'b0);
    load_byte(8'h00, 4'b0001);
    load_byte(8'h07, 4'b0000);
    load_byte(8'h00, 4'b0001);
    check("z3m_done", {7'd0, chain_done}, 8'd1);
    check("z3m_flags", {4'd0, flags_q}, 8'h00);
    start(3'd2, 1'b0);
    load_byte(8'h11, 4'b0010);
    check("stall_c", {7'd0, carry_to_alu}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", {7'd0, chain_busy}, 8'd1);
      check("stall_done", {7'd0, chain_done}, 8'd0);
      check("stall_c_hold", {7'd0, carry_to_alu}, 8'd1);
    end
    start(3'd2, 1'b0);
    check("restart_c", {7'd0, carry_to_alu}, 8'd0);
    load_byte(8'h00, 4'b0001);
    load_byte(8'h00, 4'b0001);
    check("restart_2_done", {7'd0, chain_done}, 8'd0);
    check("restart_2_busy", {7'd0, chain_busy}, 8'd1);
    load_byte(8'h00, 4'b0001);
    check("restart_done", {7'd0, chain_done}, 8'd1);
    check("restart_z", {4'd0, flags_q}, 8'h01);
    start(3'd3, 1'b0);
    load_byte(8'h33, 4'b0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    carry_init = 1'b1;
    #1;
    check("mid_busy", {7'd0, chain_busy}, 8'd0);
    check("mid_flags", {4'd0, flags_q}, 8'h00);
    check("mid_done", {7'd0, chain_done}, 8'd0);
    check("mid_cinit", {7'd0, carry_to_alu}, 8'd1);
    tick();
    check("mid_done2", {7'd0, chain_done}, 8'd0);
    result_in = 8'h9E;
    we_result = 1'b1;
    tick();
    we_result = 1'b0;
    check("we_result", result_q, 8'h9E);
    check("we_result_flags", {4'd0, flags_q}, 8'h00);
    flags_in = 4'b0001;
    we_flags = 1'b1;
`ifdef FLAGS_BYPASS_EN
    chk_cond(4'd0, 1'b1);
`else
    chk_cond(4'd0, 1'b0);
`endif
    tick();
    we_flags = 1'b0;
    chk_cond(4'd0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_flags_unit.md
Name: alu_flags_unit

Overview:
- Registered stage directly downstream of the 8-bit ALU.
- Latches the ALU result byte and its 4 flags (zero, carry, sign, overflow).
- Evaluates branch conditions for the control unit.
- Sequences multi-byte (chained) arithmetic by feeding the stored carry back to the ALU carry input and accumulating a whole-word zero flag.

Parameters:
- MAX_LEN_W, 3, width of chain_len; a chain covers chain_len+1 bytes (1..8).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- result_in  in  8  ALU result byte
- flags_in  in  4  ALU flags: [0]=Z, [1]=C, [2]=S, [3]=V
- we_result  in  1  load result_in into result_q
- we_flags  in  1  load flags_in into flags_q; counts one byte when chaining
- carry_init  in  1  carry for single-byte ops and for the first byte of a chain
- chain_start  in  1  begin a multi-byte chain
- chain_len  in  MAX_LEN_W  chain byte count minus 1
- cond  in  4  condition select
- result_q  out  8  latched result
- flags_q  out  4  latched flags; Z is the word-accumulated zero during and after a chain
- carry_to_alu  out  1  drives the ALU carry_in
- cond_true  out  1  selected condition holds
- chain_busy  out  1  high in state CHAIN
- chain_done  out  1  one-cycle pulse after the last chained byte's flags load

Behaviour:
- Reset (rst=1 at edge):
  - result_q=0, flags_q=0, state=IDLE, byte counter=0, chain_done=0.
  - Reset overrides all other inputs, including mid-chain; the aborted chain produces no chain_done.
- we_result: result_q <= result_in next edge; independent of the FSM.
- States are IDLE and CHAIN.
- IDLE:
  - carry_to_alu = carry_init (combinational).
  - we_flags: flags_q <= flags_in.
  - chain_start: counter <= chain_len, state <= CHAIN, Z accumulator preset to 1.
  - chain_start together with we_flags: flags load normally, the byte is not counted, chain starts.
- CHAIN:
  - carry_to_alu = carry_init for the first byte; after that it is flags_q[1], the previous byte's carry.
  - On each we_flags:
    - flags_q[3:1] <= flags_in[3:1].
    - flags_q[0] <= flags_q_acc & flags_in[0]. The first byte uses preset 1.
    - If counter==0: state <= IDLE and chain_done=1 the next cycle. Otherwise counter decrements.
  - chain_start in CHAIN restarts the chain: counter reloads and Z preset is restored. A we_flags in the same cycle is not counted.
  - Cycles without we_flags hold all state (stalls are allowed).
- chain_done: registered; high exactly one cycle; 0 otherwise.
- cond_true (combinational from flags_q):
  - 0 Z, 1 !Z, 2 C, 3 !C, 4 S, 5 !S, 6 V, 7 !V
  - 8 S^V (signed less-than), 9 !(S^V), 10 C&!Z (unsigned greater-than), 11 !C|Z
  - 12 always 1
  - 13-15 always 0
- Latency:
  - flags visible on flags_q and cond_true 1 cycle after we_flags.
  - carry_to_alu for byte k+1 is valid in the cycle after byte k's we_flags.

Optional Feature:
- Macro FLAGS_BYPASS_EN.
- Defined: cond_true and carry_to_alu (chained bytes after the first) use flags_in instead of flags_q whenever we_flags=1 that cycle. Z uses the accumulated value in CHAIN. This gives branch-on-same-cycle forwarding.
- Undefined: both outputs derive only from registered flags_q; no combinational path from flags_in to outputs.

Test Plan:
- Reset:
  - Stimulus: drive rst=1 for 2 cycles with we_flags=1, flags_in=4'hF.
  - Response: flags_q=0, result_q=0, chain_busy=0, chain_done=0, cond=12 gives cond_true=1, cond=0 gives 0.
- Single load:
  - Stimulus: flags_in=4'b1010 (V,C), we_flags=1.
  - Response: next cycle flags_q=4'b1010; cond 2=1, 6=1, 8=1 (S=0,V=1), 10=1, 1=1.
- 2-byte add chain: 0x01FF + 0x0001, chain_len=1, carry_init=0.
  - Byte 0: result 0x00, flags Z=1,C=1. Then carry_to_alu=1.
  - Byte 1: result 0x02, Z=0,C=0.
  - Response: chain_done one cycle, final flags_q[0]=0, chain_busy low after.
- Zero accumulation: 3-byte chain, all bytes Z=1 -> final flags_q[0]=1; repeat with middle byte Z=0 -> final Z=0.
- Stall and restart:
  - Stimulus: chain_len=2, one byte loaded, 3 idle cycles, then chain_start.
  - Response: counter reloads to 2, carry_to_alu=carry_init, three more we_flags are needed before chain_done.
- Reset mid-chain: rst after 1 of 4 bytes -> state IDLE, no chain_done pulse, flags_q=0; with FLAGS_BYPASS_EN, cond=0 with flags_in Z=1, we_flags=1 gives cond_true=1 the same cycle.
